// File: rtl/param_memory_unit.sv
`default_nettype none
// ============================================================================
// Module   : param_memory_unit
// Purpose  : Single-port DEPTH x DATA_W word array (DEPTH = 2**ADDR_W) behind
//            a valid/ready request interface. Reads respond one cycle after
//            acceptance. A clear-all op zeroes one word per cycle under a
//            two-state FSM. Op 11 is reserved and answered with err.
// Options  : MEM_PARITY_EN - adds one even-parity bit per word, checked on
//            read (err with data), plus the test input inj_par_err.
// Ports    : clk, rst_n           clock / async active-low reset
//            req_valid/req_ready  request handshake
//            op, addr, wdata      request fields (sampled on acceptance)
//            rsp_valid, rdata,err one-cycle response (rdata held)
//            busy                 clear-all in progress
//            inj_par_err          (MEM_PARITY_EN only) invert stored parity
// Revision : 1.0 - initial release
// ============================================================================
module param_memory_unit #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef MEM_PARITY_EN
  input  logic              inj_par_err,
`endif
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              busy
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [1:0] c_OP_RD  = 2'b00;
  localparam logic [1:0] c_OP_WR  = 2'b01;
  localparam logic [1:0] c_OP_CLR = 2'b10;
  localparam logic [1:0] c_OP_RSV = 2'b11;

  // Counter is one bit wider than the address so the terminal value is
  // always representable; termination uses an explicit compare.
  localparam logic [ADDR_W:0] c_CNT_LAST = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] c_CNT_ONE  = (ADDR_W + 1)'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W:0]     r_cnt;
  logic [DATA_W-1:0]   r_mem [DEPTH];

  logic                w_accept;
  logic [ADDR_W-1:0]   w_clr_idx;
  logic                w_rd_bad;

  assign w_accept  = req_valid & req_ready;
  assign w_clr_idx = r_cnt[ADDR_W-1:0];

`ifdef MEM_PARITY_EN
  logic r_par [DEPTH];

  // Stored parity disagreeing with the stored data flags a corrupted word.
  assign w_rd_bad = r_par[addr] ^ (^r_mem[addr]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_par[i] <= 1'b0;
    end else if (r_state == S_CLEAR) begin
      r_par[w_clr_idx] <= 1'b0;
    end else if (w_accept && (op == c_OP_WR)) begin
      r_par[addr] <= (^wdata) ^ inj_par_err;
    end
  end
`else
  assign w_rd_bad = 1'b0;
`endif

  // Word storage: clear sweep has priority; requests are not accepted then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (r_state == S_CLEAR) begin
      r_mem[w_clr_idx] <= '0;
    end else if (w_accept && (op == c_OP_WR)) begin
      r_mem[addr] <= wdata;
    end
  end

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      req_ready <= 1'b1;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rdata     <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      err       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            case (op)
              c_OP_RD: begin
                rsp_valid <= 1'b1;
                rdata     <= r_mem[addr];
                err       <= w_rd_bad;
              end
              c_OP_CLR: begin
                r_state   <= S_CLEAR;
                r_cnt     <= '0;
                req_ready <= 1'b0;
                busy      <= 1'b1;
              end
              c_OP_RSV: begin
                rsp_valid <= 1'b1;
                err       <= 1'b1;
              end
              default: ;  // write: storage handled above, no response
            endcase
          end
        end
        S_CLEAR: begin
          if (r_cnt == c_CNT_LAST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            r_cnt <= r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          req_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_param_memory_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_memory_unit
// Purpose  : Directed self-checking bench for param_memory_unit (8x8 default).
//            Inputs change and outputs are sampled on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_memory_unit;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] op;
  logic [2:0] addr;
  logic [7:0] wdata;
  logic       rsp_valid;
  logic [7:0] rdata;
  logic       err;
  logic       busy;
`ifdef MEM_PARITY_EN
  logic       inj_par_err;
`endif

  int n_chk;
  int n_err;
  int n_low;

  param_memory_unit #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .op         (op),
    .addr       (addr),
    .wdata      (wdata),
`ifdef MEM_PARITY_EN
    .inj_par_err(inj_par_err),
`endif
    .rsp_valid  (rsp_valid),
    .rdata      (rdata),
    .err        (err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present one request for one cycle; returns on the next falling edge,
  // where outputs reflect the accepting rising edge.
  task automatic req(input logic [1:0] o, input logic [2:0] a, input logic [7:0] d);
    req_valid = 1'b1;
    op        = o;
    addr      = a;
    wdata     = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic idle();
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    op = 2'b00;
    addr = '0;
    wdata = '0;
`ifdef MEM_PARITY_EN
    inj_par_err = 1'b0;
`endif
    idle();
    idle();
    chk("rst_ready", req_ready, 1);
    chk("rst_rsp",   rsp_valid, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_err",   err, 0);
    chk("rst_busy",  busy, 0);
    rst_n = 1'b1;
    idle();

    // Read from reset memory
    req(2'b00, 3'd5, 8'h00);
    chk("rd5_valid", rsp_valid, 1);
    chk("rd5_data",  rdata, 8'h00);
    chk("rd5_err",   err, 0);
    idle();
    chk("rsp_pulse", rsp_valid, 0);

    // Write then back-to-back reads
    req(2'b01, 3'd3, 8'hA5);
    chk("wr_norsp", rsp_valid, 0);
    req(2'b00, 3'd3, 8'h00);
    chk("raw_valid", rsp_valid, 1);
    chk("raw_data",  rdata, 8'hA5);
    req(2'b00, 3'd2, 8'h00);
    chk("b2b_valid", rsp_valid, 1);
    chk("rd2_data",  rdata, 8'h00);
    idle();
    chk("hold_data", rdata, 8'h00);

    // Fill memory, spot-check, then clear-all
    for (int i = 0; i < 8; i++) req(2'b01, 3'(i), 8'h10 + 8'(i));
    req(2'b00, 3'd6, 8'h00);
    chk("fill_rd6", rdata, 8'h16);
    req(2'b10, 3'd0, 8'h00);
    chk("clr_busy", busy, 1);
    // Hold a write during the clear; it must be ignored
    req_valid = 1'b1;
    op = 2'b01;
    addr = 3'd0;
    wdata = 8'hFF;
    n_low = 0;
    while (!req_ready && n_low < 20) begin
      n_low++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("clr_cycles", n_low, 8);
    chk("clr_done_busy", busy, 0);
    for (int i = 0; i < 8; i++) begin
      req(2'b00, 3'(i), 8'h00);
      chk($sformatf("clr_rd%0d", i), rdata, 8'h00);
    end

    // Reserved op leaves rdata and memory alone
    req(2'b01, 3'd1, 8'h5A);
    req(2'b01, 3'd4, 8'hC3);
    req(2'b00, 3'd4, 8'h00);
    chk("rd4_data", rdata, 8'hC3);
    req(2'b11, 3'd1, 8'h00);
    chk("rsv_valid", rsp_valid, 1);
    chk("rsv_err",   err, 1);
    chk("rsv_rdata", rdata, 8'hC3);
    idle();
    chk("rsv_errpulse", err, 0);
    req(2'b00, 3'd1, 8'h00);
    chk("rsv_mem",  rdata, 8'h5A);
    chk("rd1_err",  err, 0);

    // Reset in the 4th clear cycle
    req(2'b01, 3'd7, 8'h77);
    req(2'b10, 3'd0, 8'h00);
    idle();
    idle();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_busy",  busy, 0);
    chk("mid_rst_rdata", rdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    chk("post_rst_ready", req_ready, 1);
    req(2'b00, 3'd7, 8'h00);
    chk("post_rst_valid", rsp_valid, 1);
    chk("post_rst_rd7",   rdata, 8'h00);

`ifdef MEM_PARITY_EN
    inj_par_err = 1'b1;
    req(2'b01, 3'd0, 8'h01);
    inj_par_err = 1'b0;
    req(2'b00, 3'd0, 8'h00);
    chk("par_valid", rsp_valid, 1);
    chk("par_data",  rdata, 8'h01);
    chk("par_err",   err, 1);
    req(2'b01, 3'd2, 8'h03);
    req(2'b00, 3'd2, 8'h00);
    chk("par_ok_err", err, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
